// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing set, axis region
// encoding, sync pipeline bundle and helpers for axis totals/active start.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    REG_SYNC,
    REG_BACK,
    REG_ACTIVE,
    REG_FRONT
  } region_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic line_start;
    logic frame_start;
  } sync_bits_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return sync + bp + active + fp;
  endfunction

  function automatic int axis_start(input int sync, input int bp);
    return sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One VGA axis: counter 0..TOTAL-1 advancing on en, with decode of the
// timing region (sync, back porch, active, front porch) of the current count.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  parameter int W      = $clog2(axis_total(ACTIVE, FP, SYNC, BP))
) (
  input  logic         vga_clk,
  input  logic         clrn,
  input  logic         en,
  output logic [W-1:0] count,
  output region_e      region
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int START = axis_start(SYNC, BP);
  localparam logic [W-1:0] LAST_CNT = W'(TOTAL - 1);
  localparam logic [W:0]   SYNC_END = (W+1)'(SYNC);
  localparam logic [W:0]   ACT_BEG  = (W+1)'(START);
  localparam logic [W:0]   ACT_END  = (W+1)'(START + ACTIVE);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   count_ext;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST_CNT) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // One bit wider so an active window ending exactly at 2^W still decodes.
  always_comb begin
    count_ext = {1'b0, count_q};
    if (count_ext < SYNC_END) begin
      region = REG_SYNC;
    end else if (count_ext < ACT_BEG) begin
      region = REG_BACK;
    end else if (count_ext < ACT_END) begin
      region = REG_ACTIVE;
    end else begin
      region = REG_FRONT;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_scan_ctrl.sv
// Parametrised VGA scan controller: block-scaled RAM addressing, sync/strobe
// delay line matched to RD_LAT, colour mux. Optional VGA_SCAN_BORDER_EN: white border ring.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int SCALE_LOG2 = 3,
  parameter int COL_W      = 7,
  parameter int ROW_W      = 7,
  parameter int RGB_W      = 4,
  parameter int RD_LAT     = 0
) (
  input  logic               vga_clk,
  input  logic               clrn,
  input  logic [3*RGB_W-1:0] din,
  output logic [COL_W-1:0]   col_addr,
  output logic [ROW_W-1:0]   row_addr,
  output logic               rd_en,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [RGB_W-1:0]   r,
  output logic [RGB_W-1:0]   g,
  output logic [RGB_W-1:0]   b
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int H_START = axis_start(H_SYNC, H_BP);
  localparam int V_START = axis_start(V_SYNC, V_BP);
  localparam int L       = RD_LAT + 2;

  localparam sync_bits_t PIPE_IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0,
                                       line_start: 1'b0, frame_start: 1'b0};

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic [HW-1:0] h_offset;
  logic [VW-1:0] v_offset;
  region_e       h_region;
  region_e       v_region;
  logic          h_wrap;
  logic          h_first;
  logic          v_first;
  logic          active0;
  sync_bits_t    stage0;

  logic [COL_W-1:0]   col_addr_q, col_addr_d;
  logic [ROW_W-1:0]   row_addr_q, row_addr_d;
  logic               rd_en_q, rd_en_d;
  logic [3*RGB_W-1:0] rgb_q, rgb_d;
  sync_bits_t         pipe_q [L];
  sync_bits_t         pipe_d [L];

  assign h_wrap = (h_count == HW'(H_TOTAL - 1));

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (HW)
  ) u_h_cnt (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .en      (1'b1),
    .count   (h_count),
    .region  (h_region)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (VW)
  ) u_v_cnt (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .en      (h_wrap),
    .count   (v_count),
    .region  (v_region)
  );

  always_comb begin
    h_offset = h_count - HW'(H_START);
    v_offset = v_count - VW'(V_START);
    h_first  = (h_count == HW'(H_START));
    v_first  = (v_count == VW'(V_START));
    active0  = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);

    stage0.hs          = (h_region == REG_SYNC) ? H_POL : ~H_POL;
    stage0.vs          = (v_region == REG_SYNC) ? V_POL : ~V_POL;
    stage0.de          = active0;
    stage0.line_start  = active0 && h_first;
    stage0.frame_start = active0 && h_first && v_first;

    col_addr_d = '0;
    row_addr_d = '0;
    rd_en_d    = active0;
    if (active0) begin
      col_addr_d = COL_W'(h_offset >> SCALE_LOG2);
      row_addr_d = ROW_W'(v_offset >> SCALE_LOG2);
    end

    pipe_d[0] = stage0;
    for (int i = 1; i < L; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

`ifdef VGA_SCAN_BORDER_EN
  // Border flag travels alongside de as far as the colour register.
  logic border0;
  logic border_q [L-1];
  logic border_d [L-1];

  always_comb begin
    border0 = active0 && (h_first || v_first ||
                          h_count == HW'(H_START + H_ACTIVE - 1) ||
                          v_count == VW'(V_START + V_ACTIVE - 1));
    border_d[0] = border0;
    for (int i = 1; i < L - 1; i++) begin
      border_d[i] = border_q[i-1];
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < L - 1; i++) border_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < L - 1; i++) border_q[i] <= border_d[i];
    end
  end
`endif

  // Stage L-2 carries the position whose pixel data is on din right now.
  always_comb begin
    rgb_d = '0;
    if (pipe_q[L-2].de) begin
      rgb_d = din;
    end
`ifdef VGA_SCAN_BORDER_EN
    if (border_q[L-2]) begin
      rgb_d = '1;
    end
`endif
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      col_addr_q <= '0;
      row_addr_q <= '0;
      rd_en_q    <= 1'b0;
      rgb_q      <= '0;
      for (int i = 0; i < L; i++) pipe_q[i] <= PIPE_IDLE;
    end else begin
      col_addr_q <= col_addr_d;
      row_addr_q <= row_addr_d;
      rd_en_q    <= rd_en_d;
      rgb_q      <= rgb_d;
      for (int i = 0; i < L; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  logic [RGB_W-1:0] chan [3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign chan[gi] = rgb_q[gi*RGB_W +: RGB_W];
  end

  assign col_addr    = col_addr_q;
  assign row_addr    = row_addr_q;
  assign rd_en       = rd_en_q;
  assign hs          = pipe_q[L-1].hs;
  assign vs          = pipe_q[L-1].vs;
  assign de          = pipe_q[L-1].de;
  assign line_start  = pipe_q[L-1].line_start;
  assign frame_start = pipe_q[L-1].frame_start;
  assign r           = chan[0];
  assign g           = chan[1];
  assign b           = chan[2];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a small timing set with a 2-cycle registered RAM,
// checked every clock against an arithmetic scan-position model.
module tb_vga_scan_ctrl;

  localparam int H_ACT  = 16;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 3;
  localparam int H_BP   = 2;
  localparam int V_ACT  = 8;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 2;
  localparam bit H_POL  = 1'b1;
  localparam bit V_POL  = 1'b0;
  localparam int SC     = 1;
  localparam int COL_W  = 2;
  localparam int ROW_W  = 2;
  localparam int RGB_W  = 4;
  localparam int RD_LAT = 2;

  localparam int HT       = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int VT       = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FT       = HT * VT;
  localparam int HS0      = H_SYNC + H_BP;
  localparam int VS0      = V_SYNC + V_BP;
  localparam int L        = RD_LAT + 2;
  localparam int FIRST_FS = HS0 + VS0 * HT + L;

  logic               vga_clk = 1'b0;
  logic               clrn = 1'b0;
  logic [3*RGB_W-1:0] din;
  logic [COL_W-1:0]   col_addr;
  logic [ROW_W-1:0]   row_addr;
  logic               rd_en, hs, vs, de, line_start, frame_start;
  logic [RGB_W-1:0]   r, g, b;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int first_fs, cnt_de, cnt_ls, cnt_fs, cnt_hs, cnt_vs;

  logic [3*RGB_W-1:0] ram [16];
  logic [3*RGB_W-1:0] ram_q1 = '0;
  logic [3*RGB_W-1:0] ram_q2 = '0;

  vga_scan_ctrl #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL), .SCALE_LOG2(SC),
    .COL_W(COL_W), .ROW_W(ROW_W), .RGB_W(RGB_W), .RD_LAT(RD_LAT)
  ) dut (
    .vga_clk(vga_clk), .clrn(clrn), .din(din),
    .col_addr(col_addr), .row_addr(row_addr), .rd_en(rd_en),
    .hs(hs), .vs(vs), .de(de), .line_start(line_start), .frame_start(frame_start),
    .r(r), .g(g), .b(b)
  );

  always #5 vga_clk = ~vga_clk;

  // Two-cycle registered pixel store.
  always @(posedge vga_clk) begin
    ram_q1 <= ram[{row_addr, col_addr}];
    ram_q2 <= ram_q1;
  end
  assign din = ram_q2;

  function automatic int hpos(input int n);
    return n % HT;
  endfunction

  function automatic int vpos(input int n);
    return (n / HT) % VT;
  endfunction

  function automatic bit act(input int n);
    return hpos(n) >= HS0 && hpos(n) < HS0 + H_ACT && vpos(n) >= VS0 && vpos(n) < VS0 + V_ACT;
  endfunction

  function automatic logic [3*RGB_W-1:0] exp_rgb(input int n);
    int c;
    int rw;
    if (!act(n)) return '0;
`ifdef VGA_SCAN_BORDER_EN
    if (hpos(n) == HS0 || hpos(n) == HS0 + H_ACT - 1 || vpos(n) == VS0 || vpos(n) == VS0 + V_ACT - 1)
      return '1;
`endif
    c  = ((hpos(n) - HS0) >> SC) % (1 << COL_W);
    rw = ((vpos(n) - VS0) >> SC) % (1 << ROW_W);
    return ram[rw * (1 << COL_W) + c];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // cyc = rising edges since reset release; addresses show position cyc-1, rest cyc-L.
  task automatic check_all();
    int p;
    logic [31:0] e_rd, e_col, e_row, e_hs, e_vs, e_de, e_ls, e_fs, e_rgb;
    e_rd = 0; e_col = 0; e_row = 0;
    if (cyc >= 1) begin
      p = cyc - 1;
      if (act(p)) begin
        e_rd  = 1;
        e_col = 32'(((hpos(p) - HS0) >> SC) % (1 << COL_W));
        e_row = 32'(((vpos(p) - VS0) >> SC) % (1 << ROW_W));
      end
    end
    e_hs = 32'(!H_POL); e_vs = 32'(!V_POL);
    e_de = 0; e_ls = 0; e_fs = 0; e_rgb = 0;
    if (cyc >= L) begin
      p = cyc - L;
      e_hs  = 32'((hpos(p) < H_SYNC) ? H_POL : !H_POL);
      e_vs  = 32'((vpos(p) < V_SYNC) ? V_POL : !V_POL);
      e_de  = 32'(act(p));
      e_ls  = 32'(act(p) && hpos(p) == HS0);
      e_fs  = 32'(act(p) && hpos(p) == HS0 && vpos(p) == VS0);
      e_rgb = 32'(exp_rgb(p));
    end
    chk("rd_en", 32'(rd_en), e_rd);
    chk("col_addr", 32'(col_addr), e_col);
    chk("row_addr", 32'(row_addr), e_row);
    chk("hs", 32'(hs), e_hs);
    chk("vs", 32'(vs), e_vs);
    chk("de", 32'(de), e_de);
    chk("line_start", 32'(line_start), e_ls);
    chk("frame_start", 32'(frame_start), e_fs);
    chk("r", 32'(r), 32'(e_rgb[3:0]));
    chk("g", 32'(g), 32'(e_rgb[7:4]));
    chk("b", 32'(b), 32'(e_rgb[11:8]));
  endtask

  task automatic run(input int ncyc);
    first_fs = -1;
    cnt_de = 0; cnt_ls = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge vga_clk);
      cyc++;
      #1;
      check_all();
      if (frame_start === 1'b1 && first_fs < 0) first_fs = cyc;
      if (cyc >= L && cyc < L + FT) begin
        cnt_de += int'(de === 1'b1);
        cnt_ls += int'(line_start === 1'b1);
        cnt_fs += int'(frame_start === 1'b1);
        cnt_hs += int'(hs === H_POL);
        cnt_vs += int'(vs === V_POL);
      end
    end
  endtask

  task automatic check_frame_stats();
    chk("first_frame_start", 32'(first_fs), 32'(FIRST_FS));
    chk("de_per_frame", 32'(cnt_de), 32'(H_ACT * V_ACT));
    chk("line_start_per_frame", 32'(cnt_ls), 32'(V_ACT));
    chk("frame_start_per_frame", 32'(cnt_fs), 32'(1));
    chk("hs_active_per_frame", 32'(cnt_hs), 32'(H_SYNC * VT));
    chk("vs_active_per_frame", 32'(cnt_vs), 32'(V_SYNC * HT));
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16; i++) ram[i] = 12'($urandom);

    // Held in reset: outputs at idle levels.
    clrn = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    check_all();

    // Two full frames from release.
    @(negedge vga_clk);
    clrn = 1'b1;
    cyc = 0;
    run(2 * FT + 10);
    check_frame_stats();

    // Run into the active rows of the next frame, then reset mid-line.
    k = $urandom_range((VS0 + 2) * HT + 3, (VS0 + V_ACT - 1) * HT + HS0 + 4);
    for (int i = 0; i < k; i++) begin
      @(posedge vga_clk);
      cyc++;
      #1;
      check_all();
    end
    #2;
    clrn = 1'b0;
    #1;
    cyc = 0;
    check_all();
    k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) begin
      @(posedge vga_clk);
      #1;
      check_all();
    end
    for (int i = 0; i < 16; i++) ram[i] = 12'($urandom);

    // Fresh scan after release: full first-frame latency, no partial strobes.
    @(negedge vga_clk);
    clrn = 1'b1;
    cyc = 0;
    run(FT + 10);
    check_frame_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
